// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch timekeeping controller.
package stopwatch_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    PAUSE  = 2'd0,
    RUN    = 2'd1,
    ADJUST = 2'd2
  } state_t;

  localparam logic SEL_MIN = 1'b0;
  localparam logic SEL_SEC = 1'b1;

endpackage

// File: rtl/stopwatch_ctrl_bcd_mod60.sv
// Two-digit BCD counter wrapping after MAX_TENS*10+MAX_ONES; rst is async active-low.
module bcd_mod60
  import stopwatch_pkg::*;
#(
  parameter int MAX_TENS = 5,
  parameter int MAX_ONES = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [BCD_W-1:0] tens,
  output logic [BCD_W-1:0] ones,
  output logic             carry
);

  logic ones_wrap;
  logic tens_wrap;

  // Compare with >= so a digit can never climb past its bound.
  assign ones_wrap = (ones >= BCD_W'(MAX_ONES));
  assign tens_wrap = (tens >= BCD_W'(MAX_TENS));
  assign carry     = inc & ~clr & ones_wrap & tens_wrap;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tens <= '0;
      ones <= '0;
    end else if (clr) begin
      tens <= '0;
      ones <= '0;
    end else if (inc) begin
      if (ones_wrap) begin
        ones <= '0;
        tens <= tens_wrap ? '0 : tens + BCD_W'(1);
      end else begin
        ones <= ones + BCD_W'(1);
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch MM:SS counter with RUN/PAUSE/ADJUST control and adjust-field blink mask.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int MAX_TENS = 5,
  parameter int MAX_ONES = 9
) (
  input  logic             clk_sys,
  input  logic             rst,
  input  logic             tick_1hz,
  input  logic             tick_2hz,
  input  logic             tick_blink,
  input  logic             btn_pause,
  input  logic             btn_clear,
  input  logic             adj,
  input  logic             sel,
  output logic [BCD_W-1:0] dig_3,
  output logic [BCD_W-1:0] dig_2,
  output logic [BCD_W-1:0] dig_1,
  output logic [BCD_W-1:0] dig_0,
  output logic [3:0]       blank,
  output logic             running
);

  state_t state;
  state_t nxt_state;
  logic   phase;
  logic   nxt_phase;
  logic   sec_inc;
  logic   min_inc;
  logic   sec_carry;
  logic   min_carry;

  // Increments are gated on the current state, so a tick arriving with the
  // pause press that leaves RUN still counts, while one entering RUN does not.
  assign sec_inc = (state == RUN && tick_1hz) ||
                   (state == ADJUST && tick_2hz && sel == SEL_SEC);
  assign min_inc = (state == RUN && sec_carry) ||
                   (state == ADJUST && tick_2hz && sel == SEL_MIN);

  bcd_mod60 #(.MAX_TENS(MAX_TENS), .MAX_ONES(MAX_ONES)) u_sec (
    .clk   (clk_sys),
    .rst   (rst),
    .inc   (sec_inc),
    .clr   (btn_clear),
    .tens  (dig_1),
    .ones  (dig_0),
    .carry (sec_carry)
  );

  bcd_mod60 #(.MAX_TENS(MAX_TENS), .MAX_ONES(MAX_ONES)) u_min (
    .clk   (clk_sys),
    .rst   (rst),
    .inc   (min_inc),
    .clr   (btn_clear),
    .tens  (dig_3),
    .ones  (dig_2),
    .carry (min_carry)
  );

  always_comb begin
    nxt_state = state;
    case (state)
      PAUSE:   if (adj) nxt_state = ADJUST; else if (btn_pause) nxt_state = RUN;
      RUN:     if (adj) nxt_state = ADJUST; else if (btn_pause) nxt_state = PAUSE;
      ADJUST:  if (!adj) nxt_state = PAUSE;
      default: nxt_state = PAUSE;
    endcase
    // Entering ADJUST forces the blank phase so the field disappears first.
    if (state != ADJUST && nxt_state == ADJUST) nxt_phase = 1'b1;
    else                                        nxt_phase = phase ^ tick_blink;
  end

  always_ff @(posedge clk_sys or negedge rst) begin
    if (!rst) begin
      state   <= PAUSE;
      phase   <= 1'b0;
      running <= 1'b0;
      blank   <= 4'b0000;
    end else begin
      state   <= nxt_state;
      phase   <= nxt_phase;
      running <= (nxt_state == RUN);
      if (nxt_state == ADJUST && nxt_phase)
        blank <= (sel == SEL_SEC) ? 4'b0011 : 4'b1100;
      else
        blank <= 4'b0000;
    end
  end

  // The minutes wrap is deliberately dropped: 59:59 rolls to 00:00.
  logic unused_ok;
  assign unused_ok = min_carry;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed scoreboard bench for stopwatch_ctrl: stimulus queues expectations, a negedge monitor checks them.
module tb_stopwatch_ctrl;

  logic       clk_sys = 1'b0;
  logic       rst;
  logic       tick_1hz, tick_2hz, tick_blink, btn_pause, btn_clear, adj, sel;
  logic [3:0] dig_3, dig_2, dig_1, dig_0, blank;
  logic       running;

  stopwatch_ctrl dut (
    .clk_sys    (clk_sys),
    .rst        (rst),
    .tick_1hz   (tick_1hz),
    .tick_2hz   (tick_2hz),
    .tick_blink (tick_blink),
    .btn_pause  (btn_pause),
    .btn_clear  (btn_clear),
    .adj        (adj),
    .sel        (sel),
    .dig_3      (dig_3),
    .dig_2      (dig_2),
    .dig_1      (dig_1),
    .dig_0      (dig_0),
    .blank      (blank),
    .running    (running)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    string      name;
    logic [20:0] val;   // {d3,d2,d1,d0,blank,running}
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Monitor: outputs are sampled on the falling edge, away from the active edge.
  always @(negedge clk_sys) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [20:0] got;
      e   = q.pop_front();
      got = {dig_3, dig_2, dig_1, dig_0, blank, running};
      n_cmp++;
      if (got !== e.val) begin
        n_bad++;
        $display("FAIL %s: got %0d%0d:%0d%0d blank=%b run=%b, want %0d%0d:%0d%0d blank=%b run=%b",
                 e.name, got[20:17], got[16:13], got[12:9], got[8:5], got[4:1], got[0],
                 e.val[20:17], e.val[16:13], e.val[12:9], e.val[8:5], e.val[4:1], e.val[0]);
      end
    end
  end

  task automatic expect_out(input string name, input int mm, input int ss,
                            input logic [3:0] bl, input logic run);
    exp_t e;
    e.name = name;
    e.val  = {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), bl, run};
    q.push_back(e);
  endtask

  // One clock with the given one-cycle pulses; returns 1 time unit after the edge.
  task automatic cyc(input logic p, input logic c, input logic t1,
                     input logic t2, input logic tb);
    btn_pause = p; btn_clear = c; tick_1hz = t1; tick_2hz = t2; tick_blink = tb;
    @(posedge clk_sys);
    #1;
    btn_pause = 0; btn_clear = 0; tick_1hz = 0; tick_2hz = 0; tick_blink = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, run=%b want completion", running);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 0; tick_1hz = 0; tick_2hz = 0; tick_blink = 0;
    btn_pause = 0; btn_clear = 0; adj = 0; sel = 0;
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys); rst = 1;
    @(posedge clk_sys); #1;
    expect_out("reset", 0, 0, 4'b0000, 0);

    // Run and count 61 seconds
    cyc(1, 0, 0, 0, 0);                 expect_out("start_run", 0, 0, 4'b0000, 1);
    for (int i = 1; i <= 61; i++) begin
      cyc(0, 0, 1, 0, 0);
      if (i == 59) expect_out("count_59", 0, 59, 4'b0000, 1);
      if (i == 60) expect_out("sec_carry", 1, 0, 4'b0000, 1);
      if (i == 61) expect_out("count_61", 1, 1, 4'b0000, 1);
    end

    // Preload 59:58 in ADJUST
    adj = 1; sel = 0;
    cyc(0, 0, 0, 0, 0);                 expect_out("enter_adj_min", 1, 1, 4'b1100, 0);
    for (int i = 0; i < 58; i++) cyc(0, 0, 0, 1, 0);
    expect_out("adj_min_59", 59, 1, 4'b1100, 0);
    sel = 1;
    for (int i = 0; i < 57; i++) cyc(0, 0, 0, 1, 0);
    expect_out("adj_sec_58", 59, 58, 4'b0011, 0);
    cyc(1, 0, 0, 0, 0);                 expect_out("pause_ignored_adj", 59, 58, 4'b0011, 0);
    cyc(0, 0, 1, 0, 0);                 expect_out("t1_ignored_adj", 59, 58, 4'b0011, 0);
    adj = 0;
    cyc(0, 0, 0, 0, 0);                 expect_out("exit_adj", 59, 58, 4'b0000, 0);
    cyc(0, 0, 1, 0, 0);                 expect_out("t1_ignored_pause", 59, 58, 4'b0000, 0);
    cyc(0, 0, 0, 1, 0);                 expect_out("t2_ignored_pause", 59, 58, 4'b0000, 0);
    cyc(1, 0, 1, 0, 0);                 expect_out("pause_tick_to_run", 59, 58, 4'b0000, 1);
    cyc(0, 0, 1, 0, 0);                 expect_out("count_5959", 59, 59, 4'b0000, 1);
    cyc(0, 0, 1, 0, 0);                 expect_out("wrap_0000", 0, 0, 4'b0000, 1);

    // Seconds-field adjust and blink, entry coincident with tick_blink
    adj = 1; sel = 1;
    cyc(0, 0, 0, 0, 1);                 expect_out("enter_adj_blink", 0, 0, 4'b0011, 0);
    for (int i = 0; i < 59; i++) cyc(0, 0, 0, 1, 0);
    expect_out("adj_sec_59", 0, 59, 4'b0011, 0);
    cyc(0, 0, 0, 0, 1);                 expect_out("blink_off", 0, 59, 4'b0000, 0);
    cyc(0, 0, 0, 0, 1);                 expect_out("blink_on", 0, 59, 4'b0011, 0);
    cyc(0, 0, 0, 1, 0);                 expect_out("adj_sec_wrap_nocarry", 0, 0, 4'b0011, 0);
    sel = 0;
    cyc(0, 0, 0, 0, 0);                 expect_out("sel_change_blank", 0, 0, 4'b1100, 0);

    // Preload 12:34, then clear with a coincident tick in RUN
    for (int i = 0; i < 12; i++) cyc(0, 0, 0, 1, 0);
    sel = 1;
    for (int i = 0; i < 34; i++) cyc(0, 0, 0, 1, 0);
    expect_out("adj_1234", 12, 34, 4'b0011, 0);
    adj = 0;
    cyc(0, 0, 0, 0, 0);                 expect_out("pause_1234", 12, 34, 4'b0000, 0);
    cyc(1, 0, 0, 0, 0);                 expect_out("run_1234", 12, 34, 4'b0000, 1);
    cyc(0, 1, 1, 0, 0);                 expect_out("clear_beats_tick", 0, 0, 4'b0000, 1);
    cyc(0, 0, 1, 0, 0);                 expect_out("count_after_clear", 0, 1, 4'b0000, 1);

    // adj overrides btn_pause
    adj = 1;
    cyc(1, 0, 0, 0, 0);                 expect_out("adj_beats_pause", 0, 1, 4'b0011, 0);
    adj = 0;
    cyc(0, 0, 0, 0, 0);                 expect_out("adj_to_pause", 0, 1, 4'b0000, 0);
    cyc(1, 0, 0, 0, 0);                 expect_out("pause_to_run", 0, 1, 4'b0000, 1);
    cyc(1, 0, 1, 0, 0);                 expect_out("run_pause_tick", 0, 2, 4'b0000, 0);
    cyc(0, 1, 0, 0, 0);                 expect_out("clear_in_pause", 0, 0, 4'b0000, 0);

    // Reach 03:07 in RUN, then assert reset between edges
    cyc(1, 0, 0, 0, 0);                 expect_out("rerun", 0, 0, 4'b0000, 1);
    for (int i = 0; i < 187; i++) cyc(0, 0, 1, 0, 0);
    expect_out("count_0307", 3, 7, 4'b0000, 1);
    @(negedge clk_sys);
    #2;
    rst = 0;
    #1;
    expect_out("async_reset", 0, 0, 4'b0000, 0);
    @(negedge clk_sys);
    @(negedge clk_sys);
    rst = 1;
    cyc(0, 0, 1, 0, 0);                 expect_out("post_reset_t1", 0, 0, 4'b0000, 0);
    cyc(0, 0, 0, 1, 0);                 expect_out("post_reset_t2", 0, 0, 4'b0000, 0);
    cyc(1, 0, 0, 0, 0);                 expect_out("post_reset_run", 0, 0, 4'b0000, 1);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk_sys);
    #1;
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Timekeeping and mode controller for the stopwatch. It holds the MM:SS count as four BCD digits and runs the RUN / PAUSE / ADJUST state machine from the pause, clear, adj and sel controls. It also produces a per-digit blank mask so the display multiplexer can blink the field being adjusted. It sits between the clock-divider tick outputs and the 7-segment display multiplexer, and drives that multiplexer's digit and blank inputs.

## Interface
Parameters:
- MAX_TENS, 5, upper bound of a tens digit (field wraps after MAX_TENS·10+9)
- MAX_ONES, 9, upper bound of a ones digit

Ports:
- clk_sys  in  1  system clock; all logic is on the rising edge
- rst  in  1  asynchronous, active-low reset
- tick_1hz  in  1  one-cycle count-enable pulse, 1 Hz
- tick_2hz  in  1  one-cycle adjust-enable pulse, 2 Hz
- tick_blink  in  1  one-cycle pulse that toggles the blink phase
- btn_pause  in  1  one-cycle pulse, already debounced; toggles RUN/PAUSE
- btn_clear  in  1  one-cycle pulse, already debounced; zeroes the count
- adj  in  1  level; 1 = adjust mode
- sel  in  1  level; field to adjust: 0 = minutes, 1 = seconds
- dig_3  out  4  minutes tens (BCD)
- dig_2  out  4  minutes ones
- dig_1  out  4  seconds tens
- dig_0  out  4  seconds ones
- blank  out  4  bit i = 1 blanks digit i
- running  out  1  1 while in RUN

## Operation
- States: PAUSE, RUN, ADJUST.
- Reset state: PAUSE. All digits 0. blank = 4'b0000. running = 0. Blink phase = 0.
- From PAUSE:
  - btn_pause → RUN.
  - adj = 1 → ADJUST.
- From RUN:
  - btn_pause → PAUSE.
  - adj = 1 → ADJUST.
- From ADJUST:
  - adj = 0 → PAUSE.
  - btn_pause is ignored.
- Priority: adj overrides btn_pause in the same cycle.
- Counting in RUN, on tick_1hz:
  - Seconds increment.
  - 59 → 00 carries into minutes.
  - 59:59 → 00:00.
- Adjusting in ADJUST, on tick_2hz:
  - The selected field (sel) increments; 59 → 00.
  - No carry into the other field.
  - The unselected field holds.
- BCD rules:
  - Ones digit wraps at MAX_ONES and increments the tens digit.
  - Tens digit wraps at MAX_TENS only when ones also wraps.
  - Digits never hold values above 9.
- btn_clear:
  - Zeroes all four digits in any state. State is unchanged.
  - Clear beats a simultaneous tick.
- Blink:
  - The phase register toggles on tick_blink.
  - The phase is forced to 1 on the cycle ADJUST is entered, so the field blanks first.
- blank output:
  - Outside ADJUST: 4'b0000.
  - In ADJUST with phase 1: 4'b1100 if sel = 0, 4'b0011 if sel = 1.
  - In ADJUST with phase 0: 4'b0000.
- Changing sel in ADJUST takes effect on the next tick_2hz and the next blank evaluation.

## Timing
- Every output is registered, so there is no combinational path from any input to any output.
- Latency is 1 cycle from any input to its output:
  - A tick or button sampled at edge N is reflected on dig_*/blank/running after edge N.
- Simultaneous events in RUN:
  - btn_pause with tick_1hz: the tick is applied, then the state becomes PAUSE.
- Simultaneous events in PAUSE:
  - btn_pause with tick_1hz: the state becomes RUN and the tick is not applied.
- Ticks are ignored in states where they have no meaning (tick_1hz outside RUN, tick_2hz outside ADJUST).
- Reset is asynchronous:
  - Assertion mid-count immediately returns all outputs to their reset values.
  - Deassertion is synchronised upstream.

## Structure
- Package stopwatch_pkg holds:
  - the state enum (PAUSE, RUN, ADJUST);
  - the BCD width constant (4);
  - the field-select encoding (SEL_MIN = 0, SEL_SEC = 1).
- Sub-module bcd_mod60:
  - Two-digit BCD counter with ports inc, clr, tens, ones, and carry (asserted on the 59→00 increment).
  - Instantiated twice: seconds and minutes.
  - The top level gates inc per state and sel.

## Test plan
- Reset then btn_pause, then 61 tick_1hz pulses → digits 01:01, running = 1.
- Preload 59:58 via ADJUST, exit, btn_pause, then 2 tick_1hz → 59:59 then 00:00; no carry beyond minutes.
- ADJUST with sel = 1 from 00:59 and one tick_2hz → 00:00, minutes unchanged. blank toggles 4'b0011 / 4'b0000 on each tick_blink, starting 4'b0011.
- btn_clear coincident with tick_1hz at 12:34 in RUN → 00:00, still RUN. btn_pause coincident with adj = 1 → ADJUST, running = 0.
- Assert rst while in RUN at 03:07 between clock edges → outputs 00:00 immediately, blank = 0, running = 0. After deassertion the state is PAUSE and ticks are ignored.
